// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V style load/store unit bridging a request channel to a simple memory bus
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic [ADDR_WIDTH-1:0]   bus_address,
    output logic [DATA_WIDTH-1:0]   bus_wr_data,
    output logic [DATA_WIDTH/8-1:0] bus_byte_enable,
    output logic                    bus_wr_enable,
    output logic                    bus_rd_enable,
    input  logic [DATA_WIDTH-1:0]   bus_read_data,
    input  logic                    bus_ack,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic [1:0]              resp_error
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wait_q, wait_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            error_q, error_d;

    logic                  req_illegal;
    logic [2:0]            req_align_mask;

    always_comb begin
        case (req_funct3[1:0])
            2'd0:    req_align_mask = 3'b000;
            2'd1:    req_align_mask = 3'b001;
            2'd2:    req_align_mask = 3'b011;
            default: req_align_mask = 3'b111;
        endcase
        req_illegal = (req_funct3 == 3'b111)
                   || (req_write && req_funct3[2])
                   || ((req_address[2:0] & req_align_mask) != 3'b000);
        // Doubleword and WU only exist on the 64-bit datapath
        if (DATA_WIDTH == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110))
            req_illegal = 1'b1;
    end

    logic [OFFW-1:0] off;
    logic [NB-1:0]   be_base;
    logic [2:0]      lane_mask;
    logic [6:0]      ext_bits;

    assign off = addr_q[OFFW-1:0];

    always_comb begin
        case (funct3_q[1:0])
            2'd0: begin
                be_base   = NB'(8'h01);
                lane_mask = 3'b000;
                ext_bits  = 7'd8;
            end
            2'd1: begin
                be_base   = NB'(8'h03);
                lane_mask = 3'b001;
                ext_bits  = 7'd16;
            end
            2'd2: begin
                be_base   = NB'(8'h0F);
                lane_mask = 3'b011;
                ext_bits  = 7'd32;
            end
            default: begin
                be_base   = NB'(8'hFF);
                lane_mask = 3'b111;
                ext_bits  = 7'(DATA_WIDTH);
            end
        endcase
    end

    // Each lane takes the store byte at (lane index modulo access size)
    logic [DATA_WIDTH-1:0] wr_data_rep;
    logic [OFFW-1:0]       lane;

    always_comb begin
        wr_data_rep = '0;
        lane        = '0;
        for (int i = 0; i < NB; i++) begin
            lane = OFFW'(i) & lane_mask[OFFW-1:0];
            wr_data_rep[i*8 +: 8] = wdata_q[{lane, 3'b000} +: 8];
        end
    end

    logic [DATA_WIDTH-1:0] rd_shifted;
    logic [DATA_WIDTH-1:0] ext_mask;
    logic [DATA_WIDTH-1:0] ext_top;
    logic [DATA_WIDTH-1:0] load_data;

    always_comb begin
        rd_shifted = bus_read_data >> {off, 3'b000};
        ext_mask   = ~({DATA_WIDTH{1'b1}} << ext_bits);
        ext_top    = ext_mask & ~(ext_mask >> 1);
        load_data  = rd_shifted & ext_mask;
        if (!funct3_q[2] && ((rd_shifted & ext_top) != '0))
            load_data = load_data | ~ext_mask;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_address;
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    wait_d   = 8'd0;
                    if (req_illegal) begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        error_d = 2'b01;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack on the timeout edge takes priority over the timeout
                if (bus_ack) begin
                    state_d = ST_RESP;
                    error_d = 2'b00;
                    rdata_d = write_q ? '0 : load_data;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_RESP;
                        error_d = 2'b10;
                        rdata_d = '0;
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            wdata_q  <= '0;
            wait_q   <= 8'd0;
            rdata_q  <= '0;
            error_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    logic in_access;

    assign in_access       = (state_q == ST_ACCESS) && !reset;
    assign req_ready       = (state_q == ST_IDLE) && !reset;
    assign resp_valid      = (state_q == ST_RESP) && !reset;
    assign bus_rd_enable   = in_access && !write_q;
    assign bus_wr_enable   = in_access && write_q;
    assign bus_byte_enable = in_access ? (be_base << off) : '0;
    assign bus_address     = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    assign bus_wr_data     = wr_data_rep;
    assign resp_rdata      = rdata_q;
    assign resp_error      = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit, 32-bit and 64-bit instances
`timescale 1ns/1ps
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  err;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t a_e, b_e;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [2:0]  a_funct3;
    logic [31:0] a_addr, a_wdata, a_bus_addr, a_bus_wd, a_bus_rd, a_resp_rdata;
    logic [3:0]  a_be;
    logic        a_wr_en, a_rd_en, a_ack, a_resp_valid, a_resp_ready;
    logic [1:0]  a_resp_err;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [2:0]  b_funct3;
    logic [31:0] b_addr, b_bus_addr;
    logic [63:0] b_wdata, b_bus_wd, b_bus_rd, b_resp_rdata;
    logic [7:0]  b_be;
    logic        b_wr_en, b_rd_en, b_ack, b_resp_valid, b_resp_ready;
    logic [1:0]  b_resp_err;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(3)) u_a (
        .clk(clk), .reset(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_funct3(a_funct3), .req_address(a_addr), .req_wdata(a_wdata),
        .bus_address(a_bus_addr), .bus_wr_data(a_bus_wd), .bus_byte_enable(a_be),
        .bus_wr_enable(a_wr_en), .bus_rd_enable(a_rd_en), .bus_read_data(a_bus_rd),
        .bus_ack(a_ack), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_error(a_resp_err)
    );

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(15)) u_b (
        .clk(clk), .reset(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_funct3(b_funct3), .req_address(b_addr), .req_wdata(b_wdata),
        .bus_address(b_bus_addr), .bus_wr_data(b_bus_wd), .bus_byte_enable(b_be),
        .bus_wr_enable(b_wr_en), .bus_rd_enable(b_rd_en), .bus_read_data(b_bus_rd),
        .bus_ack(b_ack), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && a_resp_valid && a_resp_ready) begin
            if (a_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_resp: got rdata %h error %b with nothing expected", a_resp_rdata, a_resp_err);
            end else begin
                a_e = a_q.pop_front();
                chk("a_resp_rdata", 64'(a_resp_rdata), a_e.rd);
                chk("a_resp_error", 64'(a_resp_err), 64'(a_e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_resp_valid && b_resp_ready) begin
            if (b_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_resp: got rdata %h error %b with nothing expected", b_resp_rdata, b_resp_err);
            end else begin
                b_e = b_q.pop_front();
                chk("b_resp_rdata", b_resp_rdata, b_e.rd);
                chk("b_resp_error", 64'(b_resp_err), 64'(b_e.err));
            end
        end
    end

    // exp_be == 0 marks a request expected to be rejected as illegal
    task automatic a_txn(input string name, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_at, input logic [31:0] rd_data,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic [1:0] exp_err, input int hold);
        int   n;
        int   exp_n;
        exp_t e;
        e.rd  = 64'(exp_rd);
        e.err = exp_err;
        a_q.push_back(e);
        exp_n = (exp_be == 4'd0) ? 0 : ((ack_at < 0) ? 3 : ack_at + 1);
        a_resp_ready = (hold == 0);
        a_req_write  = wr;
        a_funct3     = f3;
        a_addr       = addr;
        a_wdata      = wdata;
        a_req_valid  = 1'b1;
        @(negedge clk);
        chk({name, "_req_ready"}, 64'(a_req_ready), 64'd1);
        tick();
        a_req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_rd_en"}, 64'(a_rd_en), 64'((exp_be != 4'd0) && !wr));
        chk({name, "_wr_en"}, 64'(a_wr_en), 64'((exp_be != 4'd0) && wr));
        chk({name, "_be"}, 64'(a_be), 64'(exp_be));
        if (exp_be != 4'd0) begin
            chk({name, "_bus_addr"}, 64'(a_bus_addr), 64'(addr & 32'hFFFF_FFFC));
            if (wr)
                chk({name, "_bus_wd"}, 64'(a_bus_wd), 64'(exp_wd));
        end
        n = 0;
        while (!a_resp_valid && n < 20) begin
            a_ack    = (n == ack_at);
            a_bus_rd = rd_data;
            tick();
            n++;
        end
        a_ack = 1'b0;
        chk({name, "_resp_seen"}, 64'(a_resp_valid), 64'd1);
        chk({name, "_access_cycles"}, 64'(n), 64'(exp_n));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, 64'(a_resp_valid), 64'd1);
            chk({name, "_hold_req_ready"}, 64'(a_req_ready), 64'd0);
            chk({name, "_hold_rdata"}, 64'(a_resp_rdata), 64'(exp_rd));
            chk({name, "_hold_error"}, 64'(a_resp_err), 64'(exp_err));
            tick();
        end
        a_resp_ready = 1'b1;
        @(negedge clk);
        chk({name, "_resp_bus_idle"}, 64'({a_rd_en, a_wr_en, a_be}), 64'd0);
        tick();
    endtask

    task automatic b_txn(input string name, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rd_data, input logic [7:0] exp_be,
                         input logic [63:0] exp_wd, input logic [63:0] exp_rd);
        exp_t e;
        e.rd  = exp_rd;
        e.err = 2'b00;
        b_q.push_back(e);
        b_resp_ready = 1'b1;
        b_req_write  = wr;
        b_funct3     = f3;
        b_addr       = addr;
        b_wdata      = wdata;
        b_req_valid  = 1'b1;
        @(negedge clk);
        chk({name, "_req_ready"}, 64'(b_req_ready), 64'd1);
        tick();
        b_req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_be"}, 64'(b_be), 64'(exp_be));
        chk({name, "_bus_addr"}, 64'(b_bus_addr), 64'(addr & 32'hFFFF_FFF8));
        chk({name, "_en"}, 64'({b_rd_en, b_wr_en}), wr ? 64'd1 : 64'd2);
        if (wr)
            chk({name, "_bus_wd"}, b_bus_wd, exp_wd);
        b_ack    = 1'b1;
        b_bus_rd = rd_data;
        tick();
        b_ack = 1'b0;
        @(negedge clk);
        chk({name, "_resp_seen"}, 64'(b_resp_valid), 64'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_funct3 = 3'b000; a_addr = '0; a_wdata = '0;
        a_bus_rd = '0; a_ack = 1'b0; a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_funct3 = 3'b000; b_addr = '0; b_wdata = '0;
        b_bus_rd = '0; b_ack = 1'b0; b_resp_ready = 1'b1;
        #1;
        chk("reset_req_ready", 64'({a_req_ready, b_req_ready}), 64'd0);
        chk("reset_resp_valid", 64'({a_resp_valid, b_resp_valid}), 64'd0);
        chk("reset_enables", 64'({a_rd_en, a_wr_en, a_be, b_rd_en, b_wr_en, b_be}), 64'd0);
        chk("reset_resp_data", 64'({a_resp_rdata, a_resp_err}), 64'd0);
        chk("reset_wait_cnt", 64'(u_a.wait_q), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", 64'(a_req_ready), 64'd1);
        tick();

        a_txn("lb_103",    1'b0, 3'b000, 32'h103, 32'h0,         1,  32'h80FF_FF12, 4'b1000, 32'h0,         32'hFFFF_FF80, 2'b00, 0);
        a_txn("sh_202",    1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 0,  32'h0,         4'b1100, 32'hBEEF_BEEF, 32'h0,         2'b00, 0);
        a_txn("lw_mis",    1'b0, 3'b010, 32'h101, 32'h0,         0,  32'h0,         4'b0000, 32'h0,         32'h0,         2'b01, 0);
        a_txn("lw_tmo",    1'b0, 3'b010, 32'h100, 32'h0,         -1, 32'hDEAD_BEEF, 4'b1111, 32'h0,         32'h0,         2'b10, 0);
        a_txn("lw_ackedge",1'b0, 3'b010, 32'h104, 32'h0,         2,  32'h1234_5678, 4'b1111, 32'h0,         32'h1234_5678, 2'b00, 0);
        a_txn("lhu_bp",    1'b0, 3'b101, 32'h102, 32'h0,         0,  32'hABCD_0000, 4'b1100, 32'h0,         32'h0000_ABCD, 2'b00, 4);
        a_txn("lh_102",    1'b0, 3'b001, 32'h102, 32'h0,         0,  32'h8001_0000, 4'b1100, 32'h0,         32'hFFFF_8001, 2'b00, 0);
        a_txn("sb_001",    1'b1, 3'b000, 32'h001, 32'h0000_005A, 0,  32'h0,         4'b0010, 32'h5A5A_5A5A, 32'h0,         2'b00, 0);
        a_txn("st_f3_100", 1'b1, 3'b100, 32'h000, 32'h1,         0,  32'h0,         4'b0000, 32'h0,         32'h0,         2'b01, 0);
        a_txn("ld_on32",   1'b0, 3'b011, 32'h000, 32'h0,         0,  32'h0,         4'b0000, 32'h0,         32'h0,         2'b01, 0);
        a_txn("f3_111",    1'b0, 3'b111, 32'h000, 32'h0,         0,  32'h0,         4'b0000, 32'h0,         32'h0,         2'b01, 0);
        a_txn("lwu_on32",  1'b0, 3'b110, 32'h000, 32'h0,         0,  32'h0,         4'b0000, 32'h0,         32'h0,         2'b01, 0);
        a_txn("sw_008",    1'b1, 3'b010, 32'h008, 32'hDEAD_BEEF, 1,  32'h0,         4'b1111, 32'hDEAD_BEEF, 32'h0,         2'b00, 0);

        a_req_write = 1'b0; a_funct3 = 3'b010; a_addr = 32'h40; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_rd_en_before", 64'(a_rd_en), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_enables", 64'({a_rd_en, a_wr_en, a_be}), 64'd0);
        chk("midrst_valids", 64'({a_req_ready, a_resp_valid}), 64'd0);
        tick();
        rst = 1'b0;
        a_txn("lbu_after_rst", 1'b0, 3'b100, 32'h003, 32'h0, 0, 32'h8000_0000, 4'b1000, 32'h0, 32'h0000_0080, 2'b00, 0);

        b_txn("b_lwu_4",  1'b0, 3'b110, 32'h4, 64'h0, 64'h8000_0001_0000_0000, 8'hF0, 64'h0, 64'h0000_0000_8000_0001);
        b_txn("b_lw_4",   1'b0, 3'b010, 32'h4, 64'h0, 64'h8000_0001_0000_0000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0001);
        b_txn("b_ld_8",   1'b0, 3'b011, 32'h8, 64'h0, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h0, 64'hFEDC_BA98_7654_3210);
        b_txn("b_sw_4",   1'b1, 3'b010, 32'h4, 64'h1122_3344, 64'h0, 8'hF0, 64'h1122_3344_1122_3344, 64'h0);
        b_txn("b_lhu_6",  1'b0, 3'b101, 32'h6, 64'h0, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0, 64'h0000_0000_0000_BEEF);

        tick();
        chk("a_queue_drained", 64'(a_q.size()), 64'd0);
        chk("b_queue_drained", 64'(b_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
